hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage rv32i pipeline.
- Drives the per-stage load and synchronous-flush inputs of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC load.
- Arbitrates three event sources: memory-port waits, load-use hazards and taken branches/jumps.
- Keeps sticky memory-response flags so single-cycle responses are not lost during a freeze, plus saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imem_read  in  1  fetch request active this cycle
imem_resp  in  1  instruction memory response (one-cycle pulse)
dmem_req  in  1  MEM-stage dmem_read | dmem_write
dmem_resp  in  1  data memory response (one-cycle pulse)
id_rs1  in  5  ID-stage rs1 index
id_rs2  in  5  ID-stage rs2 index
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_dmem_read  in  1  EX-stage instruction is a load
ex_rd  in  5  EX-stage destination index
ex_br_taken  in  1  EX resolved a taken branch/jal/jalr
perf_clr  in  1  synchronous clear of all counters
pc_load  out  1  PC register load
if_id_load  out  1  IF/ID load
id_ex_load  out  1  ID/EX load
ex_mem_load  out  1  EX/MEM load
mem_wb_load  out  1  MEM/WB load
if_id_flush  out  1  IF/ID synchronous clear to reset values (bubble)
id_ex_flush  out  1  ID/EX synchronous clear (bubble)
instr_capture  out  1  datapath latches the fetched word into its hold register
stalled  out  1  state == STALL
stall_cycles  out  CNT_W  frozen-cycle count
bubble_count  out  CNT_W  load-use bubbles inserted
flush_count  out  CNT_W  branch redirects taken

Behaviour:
- Sticky flags imem_done and dmem_done (registered):
  - Set on the resp pulse.
  - Cleared on any cycle where the pipe advances (freeze=0).
- imem_wait = imem_read & ~(imem_resp | imem_done).
- dmem_wait = dmem_req & ~(dmem_resp | dmem_done).
- freeze = imem_wait | dmem_wait.
- load_use = ex_dmem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Outputs are combinational from inputs, flags and state. Priority is freeze > ex_br_taken > load_use > normal:
  - freeze: all loads 0, all flushes 0.
  - ex_br_taken: all loads 1, if_id_flush = 1, id_ex_flush = 1; load_use is ignored that cycle.
  - load_use: pc_load = 0, if_id_load = 0, id_ex_flush = 1, ex_mem_load = 1, mem_wb_load = 1.
  - normal: all loads 1, flushes 0.
- instr_capture = imem_resp & freeze. This preserves a fetch returning while dmem is still outstanding.
- FSM with 2 states:
  - RUN -> STALL when freeze.
  - STALL -> RUN on the first cycle freeze is 0. Output decode on that cycle is normal, branch or load_use per the priority above.
  - No timeout.
- Counters: each increments by 1 per qualifying cycle and saturates at all-ones (no wrap).
  - stall_cycles counts freeze cycles.
  - bubble_count counts cycles that take the load_use branch.
  - flush_count counts cycles that take the ex_br_taken branch.
  - perf_clr clears all three and has priority over increment in the same cycle.
- Reset (including mid-stall):
  - state = RUN, flags = 0, counters = 0.
  - While rst is high, all load and flush outputs, instr_capture and stalled are forced 0.
  - A resp pulse arriving during rst is dropped.
- Simultaneous resp pulses: both flags set. If both resp arrive in the same cycle as the requests, there is no freeze and zero added latency.
- ex_rd = 0 never causes a hazard.

Decomposition:
- rv32i_types additions: enum hazard_state_t {RUN, STALL}.
- Sub-module sat_counter (params W; ports clk, rst, clr, inc, count), instantiated three times.

Test Plan:
1. No hazards, imem_read = 1 with imem_resp = 1 every cycle, dmem_req = 0 -> all loads 1 and flushes 0 every cycle; all counters stay 0.
2. ex_dmem_read = 1, ex_rd = 5, id_uses_rs2 = 1, id_rs2 = 5 for one cycle -> pc_load = 0, if_id_load = 0, id_ex_flush = 1, ex_mem_load = 1; bubble_count = 1.
3. dmem_req held high, dmem_resp arrives after 4 cycles, imem_resp pulses in cycle 1 -> loads 0 for 4 cycles, instr_capture = 1 in cycle 1 only, stalled = 1; stall_cycles = 4; advance on the dmem_resp cycle; both flags clear after it.
4. ex_br_taken = 1 and load_use true in the same cycle -> if_id_flush = 1, id_ex_flush = 1, all loads 1; flush_count = 1, bubble_count = 0.
5. ex_br_taken = 1 while dmem_wait -> frozen with no flush; the redirect (flushes) is applied on the release cycle.
6. rst asserted mid-STALL with imem_done = 1, then perf_clr together with an increment when stall_cycles is at all-ones -> state RUN, flags 0, counters 0 after rst; stall_cycles = 0 after perf_clr. Separately, preload stall_cycles near all-ones (CNT_W = 4 build: 15 plus 3 freeze cycles) -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types and constants for the pipeline stall/flush scheduler.
//   hazard_state_t : RUN while the pipe flows, STALL while a memory wait froze it
//   CNT_*          : slot indices of the three performance counters
//   src_hit()      : one ID source operand matches the EX destination
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hazard_state_t;

    localparam int CNT_STALL  = 0;
    localparam int CNT_BUBBLE = 1;
    localparam int CNT_FLUSH  = 2;
    localparam int NUM_CNT    = 3;

    function automatic logic src_hit(input logic                 uses,
                                     input logic [REG_IDX_W-1:0] rs,
                                     input logic [REG_IDX_W-1:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Event inputs  : imem_read/resp, dmem_req/resp, ID source indices and use
//                   flags, EX load/destination/taken-branch, perf_clr
//   Control outs  : per-stage loads, IF/ID and ID/EX flushes, pc_load,
//                   instr_capture, stalled
//   Counters      : stall_cycles, bubble_count, flush_count (CNT_W wide)
// master = datapath side, slave = hazard controller side.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic                 imem_read;
    logic                 imem_resp;
    logic                 dmem_req;
    logic                 dmem_resp;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 ex_dmem_read;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_br_taken;
    logic                 perf_clr;

    logic                 pc_load;
    logic                 if_id_load;
    logic                 id_ex_load;
    logic                 ex_mem_load;
    logic                 mem_wb_load;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 instr_capture;
    logic                 stalled;
    logic [CNT_W-1:0]     stall_cycles;
    logic [CNT_W-1:0]     bubble_count;
    logic [CNT_W-1:0]     flush_count;

    modport master (
        output imem_read, imem_resp, dmem_req, dmem_resp,
               id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_dmem_read, ex_rd, ex_br_taken, perf_clr,
        input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, instr_capture, stalled,
               stall_cycles, bubble_count, flush_count
    );

    modport slave (
        input  imem_read, imem_resp, dmem_req, dmem_resp,
               id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_dmem_read, ex_rd, ex_br_taken, perf_clr,
        output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, instr_capture, stalled,
               stall_cycles, bubble_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : add one this cycle
//   count    : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush scheduler for the 5-stage rv32i pipeline.
//   clk, rst : clock and synchronous active-high reset
//   hz       : hazard_ctrl_if slave port carrying the memory handshake
//              status, ID/EX hazard operands, taken-branch flag, the stage
//              load/flush controls and the three performance counters
// Priority of decoded action: memory freeze > taken branch > load-use > run.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);

    hazard_state_t state_q, state_d;
    logic          imem_done_q, imem_done_d;
    logic          dmem_done_q, dmem_done_d;

    logic imem_wait;
    logic dmem_wait;
    logic freeze;
    logic load_use;
    logic take_br;
    logic take_lu;

    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    // A response already seen during this freeze counts as satisfied, so a
    // one-cycle pulse is not lost while the other port is still waiting.
    assign imem_wait = hz.imem_read & ~(hz.imem_resp | imem_done_q);
    assign dmem_wait = hz.dmem_req  & ~(hz.dmem_resp | dmem_done_q);
    assign freeze    = imem_wait | dmem_wait;

    assign load_use = hz.ex_dmem_read && (hz.ex_rd != '0) &&
                      (src_hit(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd) ||
                       src_hit(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));

    // A branch seen under freeze is deferred, not dropped: EX holds it until release.
    assign take_br = ~rst & ~freeze & hz.ex_br_taken;
    assign take_lu = ~rst & ~freeze & ~hz.ex_br_taken & load_use;

    // Sticky flags: clearing on advance wins over a same-cycle set, since
    // the pipe consumes that response as it moves.
    always_comb begin
        imem_done_d = imem_done_q;
        dmem_done_d = dmem_done_q;
        if (hz.imem_resp) imem_done_d = 1'b1;
        if (hz.dmem_resp) dmem_done_d = 1'b1;
        if (!freeze) begin
            imem_done_d = 1'b0;
            dmem_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        hz.pc_load       = 1'b0;
        hz.if_id_load    = 1'b0;
        hz.id_ex_load    = 1'b0;
        hz.ex_mem_load   = 1'b0;
        hz.mem_wb_load   = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.instr_capture = 1'b0;
        hz.stalled       = 1'b0;

        case (state_q)
            RUN:     if (freeze)  state_d = STALL;
            STALL:   if (!freeze) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (!rst) begin
            hz.stalled       = (state_q == STALL);
            // Hold a fetch word that returns while dmem keeps the pipe frozen.
            hz.instr_capture = hz.imem_resp & freeze;
            if (freeze) begin
                // everything holds
            end else if (hz.ex_br_taken) begin
                hz.pc_load     = 1'b1;
                hz.if_id_load  = 1'b1;
                hz.id_ex_load  = 1'b1;
                hz.ex_mem_load = 1'b1;
                hz.mem_wb_load = 1'b1;
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use) begin
                // Front end holds; a bubble enters EX while the back end drains.
                hz.id_ex_load  = 1'b1;
                hz.id_ex_flush = 1'b1;
                hz.ex_mem_load = 1'b1;
                hz.mem_wb_load = 1'b1;
            end else begin
                hz.pc_load     = 1'b1;
                hz.if_id_load  = 1'b1;
                hz.id_ex_load  = 1'b1;
                hz.ex_mem_load = 1'b1;
                hz.mem_wb_load = 1'b1;
            end
        end
    end

    assign cnt_inc[CNT_STALL]  = ~rst & freeze;
    assign cnt_inc[CNT_BUBBLE] = take_lu;
    assign cnt_inc[CNT_FLUSH]  = take_br;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (hz.perf_clr),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign hz.stall_cycles = cnt_val[CNT_STALL];
    assign hz.bubble_count = cnt_val[CNT_BUBBLE];
    assign hz.flush_count  = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scenario tasks drive one cycle at a time; the expected control vector for
// each cycle is queued as it is driven and popped when the combinational
// outputs are sampled at the falling edge. Counters use a 4-bit build so
// saturation is reachable in a few cycles.
// Vector bit order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush,
//                   id_ex_flush, instr_capture, stalled
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;

    localparam logic [8:0] V_FRZ  = 9'b000000000;
    localparam logic [8:0] V_NORM = 9'b111110000;
    localparam logic [8:0] V_LU   = 9'b001110100;
    localparam logic [8:0] V_BR   = 9'b111111100;
    localparam logic [8:0] V_CAP  = 9'b000000010;
    localparam logic [8:0] V_STL  = 9'b000000001;

    typedef struct packed {
        logic       rst;
        logic       ir;
        logic       irsp;
        logic       dreq;
        logic       drsp;
        logic       br;
        logic       clr;
        logic       exld;
        logic [4:0] exrd;
        logic       u1;
        logic [4:0] rs1;
        logic       u2;
        logic [4:0] rs2;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
    hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

    int checks = 0;
    int passes = 0;
    logic [8:0] sb_q [$];

    function automatic stim_t st(input logic r, ir, irsp, dreq, drsp, br, clr);
        stim_t s;
        s      = '0;
        s.rst  = r;
        s.ir   = ir;
        s.irsp = irsp;
        s.dreq = dreq;
        s.drsp = drsp;
        s.br   = br;
        s.clr  = clr;
        return s;
    endfunction

    function automatic logic [8:0] outv();
        return {hz.pc_load, hz.if_id_load, hz.id_ex_load, hz.ex_mem_load,
                hz.mem_wb_load, hz.if_id_flush, hz.id_ex_flush,
                hz.instr_capture, hz.stalled};
    endfunction

    task automatic apply(input stim_t s);
        rst             = s.rst;
        hz.imem_read    = s.ir;
        hz.imem_resp    = s.irsp;
        hz.dmem_req     = s.dreq;
        hz.dmem_resp    = s.drsp;
        hz.ex_br_taken  = s.br;
        hz.perf_clr     = s.clr;
        hz.ex_dmem_read = s.exld;
        hz.ex_rd        = s.exrd;
        hz.id_uses_rs1  = s.u1;
        hz.id_rs1       = s.rs1;
        hz.id_uses_rs2  = s.u2;
        hz.id_rs2       = s.rs2;
    endtask

    task automatic test_reset();
        stim_t s [3];
        logic [8:0] got, exp_v;
        s[0] = st(1, 1, 1, 0, 0, 0, 0);
        s[1] = st(1, 1, 0, 0, 0, 1, 0);
        s[2] = st(1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(s[i]);
            sb_q.push_back(V_FRZ);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL reset_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("reset[%0d] out=%b", i, got); end
            @(posedge clk); #1;
        end
        checks++;
        if ({hz.stall_cycles, hz.bubble_count, hz.flush_count} !== 12'h000)
            $display("FAIL reset_cnt got=%h/%h/%h exp=0/0/0", hz.stall_cycles, hz.bubble_count, hz.flush_count);
        else passes++;
    endtask

    task automatic test_normal();
        stim_t s [5];
        logic [8:0] got, exp_v;
        s[0] = st(0, 1, 1, 0, 0, 0, 0);
        s[1] = st(0, 1, 1, 0, 0, 0, 0);
        s[2] = st(0, 1, 1, 0, 0, 0, 0);       // load to x0 never hazards
        s[2].exld = 1; s[2].exrd = 5'd0; s[2].u1 = 1; s[2].rs1 = 5'd0;
        s[3] = st(0, 1, 1, 0, 0, 0, 0);       // match on an unused source
        s[3].exld = 1; s[3].exrd = 5'd7; s[3].u1 = 0; s[3].rs1 = 5'd7;
        s[4] = st(0, 1, 1, 1, 1, 0, 0);       // both responses in the request cycle
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb_q.push_back(V_NORM);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL normal_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("normal[%0d] out=%b", i, got); end
            @(posedge clk); #1;
        end
        checks++;
        if ({hz.stall_cycles, hz.bubble_count, hz.flush_count} !== 12'h000)
            $display("FAIL normal_cnt got=%h/%h/%h exp=0/0/0", hz.stall_cycles, hz.bubble_count, hz.flush_count);
        else passes++;
    endtask

    task automatic test_load_use();
        stim_t s [2];
        logic [8:0] e [2];
        logic [8:0] got, exp_v;
        s[0] = st(0, 1, 1, 0, 0, 0, 0);
        s[0].exld = 1; s[0].exrd = 5'd5; s[0].u2 = 1; s[0].rs2 = 5'd5;
        s[0].u1 = 1; s[0].rs1 = 5'd3;
        e[0] = V_LU;
        s[1] = st(0, 1, 1, 0, 0, 0, 0);
        e[1] = V_NORM;
        for (int i = 0; i < 2; i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL load_use_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("load_use[%0d] out=%b", i, got); end
            @(posedge clk); #1;
        end
        checks++;
        if (hz.bubble_count !== 4'd1) $display("FAIL load_use_bubble got=%0d exp=1", hz.bubble_count);
        else passes++;
    endtask

    task automatic test_mem_stall();
        stim_t s [7];
        logic [8:0] e [7];
        logic [8:0] got, exp_v;
        s[0] = st(0, 1, 1, 1, 0, 0, 0); e[0] = V_CAP;
        s[1] = st(0, 1, 0, 1, 0, 0, 0); e[1] = V_STL;
        s[2] = st(0, 1, 0, 1, 0, 0, 0); e[2] = V_STL;
        s[3] = st(0, 1, 0, 1, 0, 0, 0); e[3] = V_STL;
        s[4] = st(0, 1, 0, 1, 1, 0, 0); e[4] = V_NORM | V_STL;
        s[5] = st(0, 1, 0, 1, 0, 0, 0); e[5] = V_FRZ;     // flags gone -> waits again
        s[6] = st(0, 1, 1, 1, 1, 0, 0); e[6] = V_NORM | V_STL;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL mem_stall_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("mem_stall[%0d] out=%b", i, got); end
            @(posedge clk); #1;
            if (i == 4) begin
                checks++;
                if (hz.stall_cycles !== 4'd4) $display("FAIL mem_stall_cnt got=%0d exp=4", hz.stall_cycles);
                else passes++;
            end
        end
        checks++;
        if (hz.stall_cycles !== 4'd5) $display("FAIL mem_stall_cnt2 got=%0d exp=5", hz.stall_cycles);
        else passes++;
    endtask

    task automatic test_branch_over_lu();
        stim_t s [2];
        logic [8:0] e [2];
        logic [8:0] got, exp_v;
        s[0] = st(0, 1, 1, 0, 0, 1, 0);
        s[0].exld = 1; s[0].exrd = 5'd9; s[0].u1 = 1; s[0].rs1 = 5'd9;
        e[0] = V_BR;
        s[1] = st(0, 1, 1, 0, 0, 0, 0);
        e[1] = V_NORM;
        for (int i = 0; i < 2; i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL br_lu_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("br_lu[%0d] out=%b", i, got); end
            @(posedge clk); #1;
        end
        checks++;
        if ({hz.flush_count, hz.bubble_count} !== {4'd1, 4'd1})
            $display("FAIL br_lu_cnt got=flush %0d bubble %0d exp=flush 1 bubble 1", hz.flush_count, hz.bubble_count);
        else passes++;
    endtask

    task automatic test_branch_frozen();
        stim_t s [3];
        logic [8:0] e [3];
        logic [8:0] got, exp_v;
        s[0] = st(0, 0, 0, 1, 0, 1, 0); e[0] = V_FRZ;
        s[1] = st(0, 0, 0, 1, 0, 1, 0); e[1] = V_STL;
        s[2] = st(0, 0, 0, 1, 1, 1, 0); e[2] = V_BR | V_STL;
        for (int i = 0; i < 3; i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL br_frozen_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("br_frozen[%0d] out=%b", i, got); end
            @(posedge clk); #1;
        end
        checks++;
        if ({hz.flush_count, hz.stall_cycles} !== {4'd2, 4'd7})
            $display("FAIL br_frozen_cnt got=flush %0d stall %0d exp=flush 2 stall 7", hz.flush_count, hz.stall_cycles);
        else passes++;
    endtask

    task automatic test_reset_mid_stall();
        stim_t s [5];
        logic [8:0] e [5];
        logic [8:0] got, exp_v;
        s[0] = st(0, 1, 1, 1, 0, 0, 0); e[0] = V_CAP;
        s[1] = st(0, 1, 0, 1, 0, 0, 0); e[1] = V_STL;
        s[2] = st(1, 1, 1, 1, 0, 1, 0); e[2] = V_FRZ;     // resp during rst is dropped
        s[3] = st(0, 1, 0, 0, 0, 0, 0); e[3] = V_FRZ;     // RUN, imem_done cleared
        s[4] = st(0, 1, 1, 0, 0, 0, 0); e[4] = V_NORM | V_STL;
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL rst_stall_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("rst_stall[%0d] out=%b", i, got); end
            @(posedge clk); #1;
            if (i == 2) begin
                checks++;
                if ({hz.stall_cycles, hz.bubble_count, hz.flush_count} !== 12'h000)
                    $display("FAIL rst_stall_cnt got=%h/%h/%h exp=0/0/0", hz.stall_cycles, hz.bubble_count, hz.flush_count);
                else passes++;
            end
        end
        checks++;
        if (hz.stall_cycles !== 4'd1) $display("FAIL rst_stall_cnt2 got=%0d exp=1", hz.stall_cycles);
        else passes++;
    endtask

    task automatic test_saturate_clear();
        logic [8:0] got, exp_v;
        // stall_cycles starts at 1: 14 cycles reach 15, 3 more must hold it
        for (int i = 0; i < 17; i++) begin
            apply(st(0, 1, 0, 0, 0, 0, 0));
            sb_q.push_back((i == 0) ? V_FRZ : V_STL);
            @(negedge clk);
            got = outv();
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL sat_out[%0d] got=%b exp=%b", i, got, exp_v);
            else begin passes++; $display("sat[%0d] out=%b cnt=%0d", i, got, hz.stall_cycles); end
            @(posedge clk); #1;
        end
        checks++;
        if (hz.stall_cycles !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", hz.stall_cycles);
        else passes++;
        // clear while still frozen: clear beats the increment
        apply(st(0, 1, 0, 0, 0, 0, 1));
        sb_q.push_back(V_STL);
        @(negedge clk);
        got = outv();
        exp_v = sb_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL clr_out got=%b exp=%b", got, exp_v);
        else begin passes++; $display("clr out=%b", got); end
        @(posedge clk); #1;
        checks++;
        if ({hz.stall_cycles, hz.bubble_count, hz.flush_count} !== 12'h000)
            $display("FAIL clr_cnt got=%h/%h/%h exp=0/0/0", hz.stall_cycles, hz.bubble_count, hz.flush_count);
        else passes++;
        apply(st(0, 1, 1, 0, 0, 0, 0));
        sb_q.push_back(V_NORM | V_STL);
        @(negedge clk);
        got = outv();
        exp_v = sb_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL release_out got=%b exp=%b", got, exp_v);
        else begin passes++; $display("release out=%b", got); end
        @(posedge clk); #1;
        checks++;
        if (hz.stall_cycles !== 4'd0) $display("FAIL release_cnt got=%0d exp=0", hz.stall_cycles);
        else passes++;
    endtask

    initial begin
        apply(st(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        test_reset();
        test_normal();
        test_load_use();
        test_mem_stall();
        test_branch_over_lu();
        test_branch_frozen();
        test_reset_mid_stall();
        test_saturate_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
